// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC operand sequencer and its operand FIFO.
package mac_seq_pkg;

  localparam int OPW = 8;
  localparam int ACCW = 16;
  localparam logic [ACCW-1:0] SAT_VAL = 16'hFFFF;
  localparam int WORDW = 2 * OPW + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    WAIT,
    CAPTURE,
    RESULT
  } seq_state_e;

  // One buffered operand pair, laid out as {last, a, b}.
  typedef struct packed {
    logic           last;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } fifo_word_t;

endpackage

// File: rtl/mac_operand_fifo.sv
// Show-ahead synchronous FIFO for operand pairs. The pointers carry one extra
// wrap bit, so full and empty can be told apart without a separate counter.
module mac_operand_fifo
  import mac_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push_i,
  input  fifo_word_t wdata_i,
  input  logic       pop_i,
  output fifo_word_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  fifo_word_t    mem_q [DEPTH];
  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;
  logic          doPush;
  logic          doPop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Storage array; contents are don't-care while empty, so it needs no reset.
  always_ff @(posedge clock) begin
    if (doPush) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

  // Pointer update; wrapping through the extra bit is intentional.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (doPush) begin
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (doPop) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Feeds buffered operand pairs into an external accumulate-every-cycle MAC.
// The MAC is cleared before each vector, fed zeros whenever no pair is ready,
// and the finished sum is captured and offered on a result handshake.
module mac_operand_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_a,
  input  logic [OPW-1:0]   in_b,
  input  logic             in_last,
  output logic [OPW-1:0]   mac_a,
  output logic [OPW-1:0]   mac_b,
  output logic             mac_clear,
  input  logic [ACCW-1:0]  mac_s,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [ACCW-1:0]  result_data,
  output logic [CNT_W-1:0] result_count,
  output logic             result_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_state_e       state_q;
  logic [OPW-1:0]   mac_a_q;
  logic [OPW-1:0]   mac_b_q;
  logic             mac_clear_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             result_valid_q;
  logic [ACCW-1:0]  result_data_q;
  logic [CNT_W-1:0] result_count_q;
  logic             result_sat_q;

  fifo_word_t       pushWord;
  fifo_word_t       headWord;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             fifoPush;
  logic             fifoPop;

  assign pushWord = '{last: in_last, a: in_a, b: in_b};
  assign in_ready = !fifoFull;
  assign fifoPush = in_valid && !fifoFull;
  assign fifoPop  = (state_q == RUN) && !fifoEmpty;

  mac_operand_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (fifoPush),
    .wdata_i (pushWord),
    .pop_i   (fifoPop),
    .rdata_o (headWord),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Element count sticks at its maximum instead of wrapping on long vectors.
  always_comb begin
    count_d = count_q;
    if (count_q != CNT_MAX) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Sequencer FSM; every output is a register loaded for the state being entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      mac_a_q        <= '0;
      mac_b_q        <= '0;
      mac_clear_q    <= 1'b1;
      count_q        <= '0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      result_count_q <= '0;
      result_sat_q   <= 1'b0;
    end else begin
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_clear_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifoEmpty) begin
            state_q     <= CLEAR;
            mac_clear_q <= 1'b1;
          end
        end
        CLEAR: begin
          count_q <= '0;
          state_q <= RUN;
        end
        RUN: begin
          if (!fifoEmpty) begin
            mac_a_q <= headWord.a;
            mac_b_q <= headWord.b;
            count_q <= count_d;
            if (headWord.last) begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          result_data_q  <= mac_s;
          result_sat_q   <= (mac_s == SAT_VAL);
          result_count_q <= count_q;
          result_valid_q <= 1'b1;
          state_q        <= RESULT;
        end
        RESULT: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mac_a        = mac_a_q;
  assign mac_b        = mac_b_q;
  assign mac_clear    = mac_clear_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign result_count = result_count_q;
  assign result_sat   = result_sat_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for the MAC operand sequencer, with a behavioural saturating MAC
// attached to the sequencer's MAC-side ports.
module tb_mac_operand_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic             in_last = 1'b0;
  logic [7:0]       mac_a;
  logic [7:0]       mac_b;
  logic             mac_clear;
  logic [15:0]      mac_s;
  logic             result_valid;
  logic             result_ready = 1'b1;
  logic [15:0]      result_data;
  logic [CNT_W-1:0] result_count;
  logic             result_sat;

  int checks = 0;
  int failures = 0;
  int cycleNo = 0;

  typedef struct packed {
    logic [3:0]      n;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [15:0]     expData;
    logic [7:0]      expCount;
    logic            expSat;
  } vec_t;

  vec_t vecs [5];

  mac_operand_sequencer #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_last      (in_last),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_clear    (mac_clear),
    .mac_s        (mac_s),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .result_count (result_count),
    .result_sat   (result_sat)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Rising-edge counter used to measure result latency.
  always @(posedge clock) cycleNo <= cycleNo + 1;

  // External 8x8 MAC: async clear, adds A*B every edge, saturates at 0xFFFF.
  always @(posedge clock or posedge mac_clear) begin
    logic [16:0] sum;
    if (mac_clear) begin
      mac_s <= '0;
    end else begin
      sum = {1'b0, mac_s} + 17'(mac_a * mac_b);
      mac_s <= sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Presents one pair and holds it across a rising edge; waits (bounded) for room.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic last, output int driveCycle);
    int waitCycles = 0;
    @(negedge clock);
    while (!in_ready && waitCycles < 50) begin
      in_valid = 1'b0;
      @(negedge clock);
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("push_room_timeout", in_ready, 1);
    end
    driveCycle = cycleNo;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    @(posedge clock);
  endtask

  // Drops in_valid and waits (bounded) for result_valid; returns the edge count seen.
  task automatic waitResult(input int budget, output int seenCycle);
    int n = 0;
    @(negedge clock);
    in_valid = 1'b0;
    while (!result_valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("result_valid_seen", result_valid, 1);
    seenCycle = cycleNo;
  endtask

  function automatic vec_t mkVec(input int n,
                                 input logic [7:0] a0, input logic [7:0] b0,
                                 input logic [7:0] a1, input logic [7:0] b1,
                                 input logic [7:0] a2, input logic [7:0] b2,
                                 input logic [7:0] a3, input logic [7:0] b3,
                                 input logic [15:0] d, input int c, input logic s);
    vec_t v;
    v.n = 4'(n);
    v.a = {a3, a2, a1, a0};
    v.b = {b3, b2, b1, b0};
    v.expData = d;
    v.expCount = 8'(c);
    v.expSat = s;
    return v;
  endfunction

  initial begin
    int d0;
    int dTmp;
    int seen;
    bit holdOk;
    bit accepted;
    bit sawClear;
    bit dataBeforeClear;
    bit quietOk;
    int w;

    vecs[0] = mkVec(3, 10, 20, 3, 4, 255, 255, 0, 0, 16'd65237, 3, 1'b0);
    vecs[1] = mkVec(2, 255, 255, 255, 255, 0, 0, 0, 0, 16'hFFFF, 2, 1'b1);
    vecs[2] = mkVec(2, 255, 255, 2, 255, 0, 0, 0, 0, 16'hFFFF, 2, 1'b1);
    vecs[3] = mkVec(1, 0, 9, 0, 0, 0, 0, 0, 0, 16'd0, 1, 1'b0);
    vecs[4] = mkVec(4, 16, 16, 1, 2, 100, 3, 0, 7, 16'd558, 4, 1'b0);

    // Reset held for three cycles
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_mac_clear", mac_clear, 1);
    checkOutput("rst_mac_a", mac_a, 0);
    checkOutput("rst_mac_b", mac_b, 0);
    checkOutput("rst_result_valid", result_valid, 0);
    checkOutput("rst_result_data", result_data, 0);
    checkOutput("rst_result_count", result_count, 0);
    checkOutput("rst_result_sat", result_sat, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    #1 checkOutput("rel_mac_clear_held", mac_clear, 1);
    @(negedge clock);
    checkOutput("rel_mac_clear_drop", mac_clear, 0);
    checkOutput("rel_in_ready", in_ready, 1);
    repeat (2) @(negedge clock);

    // Table of back-to-back vectors with result_ready held high
    result_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < int'(vecs[i].n); j++) begin
        applyStimulus(vecs[i].a[j], vecs[i].b[j], j == int'(vecs[i].n) - 1, dTmp);
        if (j == 0) d0 = dTmp;
      end
      waitResult(40, seen);
      checkOutput($sformatf("vec%0d_latency", i), seen - d0, int'(vecs[i].n) + 5);
      checkOutput($sformatf("vec%0d_data", i), result_data, vecs[i].expData);
      checkOutput($sformatf("vec%0d_count", i), result_count, vecs[i].expCount);
      checkOutput($sformatf("vec%0d_sat", i), result_sat, vecs[i].expSat);
      @(negedge clock);
      checkOutput($sformatf("vec%0d_valid_one_cycle", i), result_valid, 0);
      @(negedge clock);
    end

    // Long vector: element count must stick at 255
    for (int i = 0; i < 260; i++) begin
      applyStimulus(8'd1, 8'd1, i == 259, dTmp);
    end
    waitResult(40, seen);
    checkOutput("long_data", result_data, 260);
    checkOutput("long_count_sat", result_count, 255);
    checkOutput("long_sat", result_sat, 0);
    @(negedge clock);

    // Sparse input: bubbles between two pairs
    applyStimulus(8'd2, 8'd3, 1'b0, d0);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("sparse_first_a", mac_a, 2);
    checkOutput("sparse_first_b", mac_b, 3);
    @(negedge clock);
    checkOutput("sparse_gap1_a", mac_a, 0);
    checkOutput("sparse_gap1_b", mac_b, 0);
    in_valid = 1'b1;
    in_a = 8'd4;
    in_b = 8'd5;
    in_last = 1'b1;
    @(negedge clock);
    checkOutput("sparse_gap2_a", mac_a, 0);
    checkOutput("sparse_gap2_b", mac_b, 0);
    in_valid = 1'b0;
    @(negedge clock);
    checkOutput("sparse_second_a", mac_a, 4);
    checkOutput("sparse_second_b", mac_b, 5);
    waitResult(40, seen);
    checkOutput("sparse_data", result_data, 26);
    checkOutput("sparse_count", result_count, 2);
    @(negedge clock);

    // Held result with the FIFO filling behind it
    result_ready = 1'b0;
    applyStimulus(8'd9, 8'd9, 1'b1, dTmp);
    waitResult(40, seen);
    checkOutput("pend_data", result_data, 81);
    applyStimulus(8'd1, 8'd1, 1'b0, dTmp);
    applyStimulus(8'd2, 8'd2, 1'b0, dTmp);
    applyStimulus(8'd3, 8'd3, 1'b0, dTmp);
    applyStimulus(8'd4, 8'd4, 1'b0, dTmp);
    @(negedge clock);
    in_valid = 1'b0;
    checkOutput("full_in_ready", in_ready, 0);
    in_a = 8'd5;
    in_b = 8'd5;
    in_last = 1'b1;
    in_valid = 1'b1;
    holdOk = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (in_ready !== 1'b0 || result_valid !== 1'b1 || result_data !== 16'd81 ||
          result_count !== 8'd1 || mac_a !== 8'd0 || mac_clear !== 1'b0) holdOk = 1'b0;
    end
    checkOutput("pend_hold_stable", holdOk, 1);
    result_ready = 1'b1;
    @(negedge clock);
    checkOutput("pend_result_drop", result_valid, 0);
    accepted = 1'b0;
    sawClear = 1'b0;
    dataBeforeClear = 1'b0;
    for (int c = 0; c < 20 && !accepted; c++) begin
      if (mac_clear) sawClear = 1'b1;
      if ((mac_a != 0 || mac_b != 0) && !sawClear) dataBeforeClear = 1'b1;
      if (in_ready) begin
        @(posedge clock);
        accepted = 1'b1;
      end
      @(negedge clock);
      if (accepted) in_valid = 1'b0;
    end
    checkOutput("fifth_accepted", accepted, 1);
    checkOutput("next_vec_clear_pulse", sawClear, 1);
    checkOutput("no_data_before_clear", dataBeforeClear, 0);
    waitResult(40, seen);
    checkOutput("drain_data", result_data, 55);
    checkOutput("drain_count", result_count, 5);
    checkOutput("drain_sat", result_sat, 0);
    @(negedge clock);

    // Reset asserted mid-vector
    applyStimulus(8'd1, 8'd2, 1'b0, dTmp);
    applyStimulus(8'd3, 8'd4, 1'b0, dTmp);
    applyStimulus(8'd5, 8'd6, 1'b0, dTmp);
    @(negedge clock);
    in_valid = 1'b0;
    w = 0;
    while (mac_a == 0 && w < 20) begin
      @(negedge clock);
      w++;
    end
    checkOutput("midrst_in_run", mac_a != 0, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_mac_clear", mac_clear, 1);
    checkOutput("midrst_mac_a", mac_a, 0);
    checkOutput("midrst_result_valid", result_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    quietOk = 1'b1;
    repeat (6) begin
      @(negedge clock);
      if (mac_clear || mac_a != 0 || mac_b != 0 || result_valid) quietOk = 1'b0;
    end
    checkOutput("midrst_fifo_flushed", quietOk, 1);
    applyStimulus(8'd7, 8'd6, 1'b1, d0);
    waitResult(40, seen);
    checkOutput("postrst_latency", seen - d0, 6);
    checkOutput("postrst_data", result_data, 42);
    checkOutput("postrst_count", result_count, 1);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
Upstream feeder and result-capture stage for the 8x8 saturating MAC unit (16-bit accumulator, active-high async clear, accumulates A*B on every clock edge).
- Accepts (a, b, last) operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Clears the MAC before each vector and drives one pair per cycle, with zero bubbles whenever no pair is available, because the MAC accumulates every cycle.
- Captures the finished dot product with an element count and a saturation flag, and presents it on a valid/ready result port.

Parameters:
DEPTH, 4, operand FIFO depth (power of 2, >=2)
CNT_W, 8, element-count width; count saturates at 2^CNT_W-1

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept; equals !full
in_a  in  8  operand A
in_b  in  8  operand B
in_last  in  1  final pair of current vector
mac_a  out  8  to MAC A (registered)
mac_b  out  8  to MAC B (registered)
mac_clear  out  1  to MAC active-high reset (registered, glitch-free)
mac_s  in  16  MAC accumulator S
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_data  out  16  captured S
result_count  out  CNT_W  pairs in vector (saturating)
result_sat  out  1  1 when captured S == 16'hFFFF

Behaviour:
- Reset, asynchronous on reset_n low, all registered:
  - FIFO empty; state IDLE.
  - mac_a=0, mac_b=0, mac_clear=1 (MAC held clear during reset); mac_clear drops on the first clock after release.
  - result_valid=0, result_data=0, result_count=0, result_sat=0.
- Push: in_valid & in_ready at the rising edge. in_ready depends only on registered full, so there is no same-cycle push-through when full, even if a pop occurs that cycle.
- Pop: internal and occurs only in RUN. Word = {last, a, b}.
- FSM, all outputs registered and Moore per state:
  - IDLE: mac_a/b=0, mac_clear=0. If FIFO non-empty -> CLEAR.
  - CLEAR (1 cycle): mac_clear=1, mac_a/b=0, count<=0 -> RUN.
  - RUN: if FIFO non-empty, pop, load mac_a/b with the popped pair next cycle, and count++ (saturating). If the popped word has last=1 -> WAIT. If the FIFO is empty, load mac_a/b=0 (bubble) and stay.
  - WAIT (1 cycle): mac_a/b still carry the last pair, which the MAC adds at this edge; load mac_a/b=0 -> CAPTURE.
  - CAPTURE (1 cycle): result_data<=mac_s, result_sat<=(mac_s==16'hFFFF), result_count<=count, result_valid<=1 -> RESULT.
  - RESULT: hold all result outputs stable while result_ready=0. The FIFO keeps accepting pushes; mac_a/b=0. On result_valid & result_ready: result_valid<=0 -> IDLE.
- Latency: single pair pushed at edge E0 into an empty block in IDLE -> result_valid high in cycle 6 (IDLE c1, CLEAR c2, RUN c3, WAIT c4, CAPTURE c5). N pairs pre-buffered back to back -> result_valid in cycle N+5.
- Width/arithmetic:
  - The sequencer performs no arithmetic on data; saturation is owned by the MAC.
  - result_sat also flags an exact 0xFFFF sum; this is accepted.
  - count saturates at 2^CNT_W-1 and never wraps.
- Boundary conditions:
  - FIFO full: in_ready=0.
  - FIFO empty mid-vector: zero bubbles, accumulation unaffected.
  - Read/write pointers are log2(DEPTH)+1 bits and wrap naturally.
  - in_last on the first pair: vector of length 1.
  - Pairs of the next vector may be buffered during RESULT; they are not popped until after CLEAR.
- Reset mid-operation: everything aborts immediately to reset values, buffered pairs are discarded, and no partial result is emitted.

Decomposition:
- Package mac_seq_pkg:
  - state enum {IDLE, CLEAR, RUN, WAIT, CAPTURE, RESULT}
  - OPW=8, ACCW=16, SAT_VAL=16'hFFFF
  - FIFO word layout {last, a, b} = 17 bits
- Sub-module mac_operand_fifo:
  - synchronous FIFO, DEPTH x 17, async active-low reset, full/empty from extended pointers
  - The sequencer top holds the FSM, count and result registers.

Test Plan:
1. Reset held 3 cycles, then released -> mac_clear=1 during reset, 0 from the first post-release cycle; all other outputs 0; in_ready=1.
2. Push (10,20),(3,4),(255,255,last) back to back, result_ready=1 -> result_data=65237 (0xFED5), result_count=3, result_sat=0, result_valid for 1 cycle at cycle 8 after the first push edge.
3. Push (255,255),(255,255,last) -> result_data=0xFFFF, result_sat=1, result_count=2.
4. Push 5 pairs while result_ready=0 and a previous result is pending, DEPTH=4 -> in_ready=0 after the 4th push; the 5th is accepted only after the FIFO drains. The held result stays stable until result_ready; the next vector starts with a mac_clear pulse.
5. Sparse input: (2,3), 4 idle cycles, (4,5,last) -> mac_a/b=0 in gap cycles; result_data=26, count=2.
6. Assert reset_n low while in RUN mid-vector -> FIFO flushed, result_valid stays 0, mac_clear=1. After release, a new single pair (7,6,last) -> result_data=42.
